// File: rtl/tdm_demux_1_4.sv
// Receive side of a 4:1 TDM link: tracks slot position from a slot-0 frame sync
// and presents each complete frame as one registered parallel word.
// Optional saturating sync-error counter port enabled by TDM_DEMUX_ERR_CNT_EN.
module tdm_demux_1_4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [4*W-1:0] out_bus,
    output logic           frame_valid,
    output logic [1:0]     sel,
    output logic           locked,
    output logic           sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]     err_count
`endif
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [W-1:0]   shadow_q [3];
    logic [W-1:0]   shadow_d [3];
    logic [4*W-1:0] out_bus_q, out_bus_d;
    logic           frame_valid_q, frame_valid_d;
    logic           sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        shadow_d      = shadow_q;
        out_bus_d     = out_bus_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        sel_d       = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A sync anywhere but slot 0 restarts the frame on this sample.
                        sync_err_d  = (sel_q != 2'd0);
                        shadow_d[0] = din;
                        sel_d       = 2'd1;
                    end else if (sel_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else if (sel_q == 2'd3) begin
                        out_bus_d     = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_valid_d = 1'b1;
                        sel_d         = 2'd0;
                    end else begin
                        shadow_d[sel_q] = din;
                        sel_d           = sel_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            sel_q         <= 2'd0;
            out_bus_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            out_bus_q     <= out_bus_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign out_bus     = out_bus_q;
    assign frame_valid = frame_valid_q;
    assign sel         = sel_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (sync_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Bench for tdm_demux_1_4: queue-based frame model checked every cycle, plus
// directed literal expectations; covers err_count when TDM_DEMUX_ERR_CNT_EN is defined.
module tb_tdm_demux_1_4;
    localparam int W = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   din = '0;
    logic           din_valid = 1'b0;
    logic           frame_sync = 1'b0;
    logic [4*W-1:0] out_bus;
    logic           frame_valid;
    logic [1:0]     sel;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0]     err_count;
`endif

    tdm_demux_1_4 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .out_bus     (out_bus),
        .frame_valid (frame_valid),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of samples collected since the last accepted sync.
    logic [W-1:0]   frame_q[$];
    bit             m_locked = 1'b0;
    logic [4*W-1:0] m_out = '0;
    bit             m_fv = 1'b0;
    bit             m_err = 1'b0;
    int             m_cnt = 0;

    always @(posedge clk) begin
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            frame_q.delete();
            m_locked = 1'b0;
            m_out    = '0;
            m_cnt    = 0;
        end else if (din_valid) begin
            if (frame_sync) begin
                if (m_locked && frame_q.size() != 0) m_err = 1'b1;
                frame_q.delete();
                frame_q.push_back(din);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (frame_q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    frame_q.push_back(din);
                    if (frame_q.size() == 4) begin
                        m_out = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
                        m_fv  = 1'b1;
                        frame_q.delete();
                    end
                end
            end
        end
        if (m_err && m_cnt < 255) m_cnt++;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_bus", 32'(out_bus), 32'(m_out));
            chk("frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("sel", 32'(sel), 32'(frame_q.size()));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("sync_err", 32'(sync_err), 32'(m_err));
            chk("fv_err_exclusive", 32'(frame_valid & sync_err), 32'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
            chk("err_count", 32'(err_count), 32'(m_cnt));
`endif
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic fs);
        din_valid  = v;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        started = 1'b1;
        rst = 1'b0;
        chk("rst_out_bus", 32'(out_bus), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);

        // Plain frame 0,1,0,1
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("frame1_fv_early", 32'(frame_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("frame1_out", 32'(out_bus), 32'b1010);
        chk("frame1_fv", 32'(frame_valid), 32'd1);
        chk("frame1_locked", 32'(locked), 32'd1);
        chk("frame1_sel", 32'(sel), 32'd0);
        idle(1);
        chk("frame1_fv_pulse", 32'(frame_valid), 32'd0);

        // Same frame with 3-cycle gaps
        cyc(1'b1, 1'b0, 1'b1); chk("gap_sel1", 32'(sel), 32'd1); idle(3); chk("gap_sel1h", 32'(sel), 32'd1);
        cyc(1'b1, 1'b1, 1'b0); chk("gap_sel2", 32'(sel), 32'd2); idle(3);
        cyc(1'b1, 1'b0, 1'b0); chk("gap_sel3", 32'(sel), 32'd3); idle(3);
        chk("gap_fv_none", 32'(frame_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("gap_out", 32'(out_bus), 32'b1010);
        chk("gap_fv", 32'(frame_valid), 32'd1);
        chk("gap_sel0", 32'(sel), 32'd0);

        // Early sync on slot 2
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("early_err", 32'(sync_err), 32'd1);
        chk("early_sel", 32'(sel), 32'd1);
        chk("early_locked", 32'(locked), 32'd1);
        chk("early_out_hold", 32'(out_bus), 32'b1010);
        cyc(1'b1, 1'b1, 1'b0);
        chk("early_err_pulse", 32'(sync_err), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("early_out_hold2", 32'(out_bus), 32'b1010);
        cyc(1'b1, 1'b0, 1'b0);
        chk("early_out", 32'(out_bus), 32'b0111);
        chk("early_fv", 32'(frame_valid), 32'd1);

        // Missing sync at slot 0
        cyc(1'b1, 1'b1, 1'b0);
        chk("miss_err", 32'(sync_err), 32'd1);
        chk("miss_locked", 32'(locked), 32'd0);
        chk("miss_sel", 32'(sel), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("hunt_no_err", 32'(sync_err), 32'd0);
        chk("hunt_locked", 32'(locked), 32'd0);
        chk("hunt_out_hold", 32'(out_bus), 32'b0111);

        // Mid-frame reset, with a valid sample presented during reset
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk("mrst_out", 32'(out_bus), 32'd0);
        chk("mrst_sel", 32'(sel), 32'd0);
        chk("mrst_locked", 32'(locked), 32'd0);
        chk("mrst_fv", 32'(frame_valid), 32'd0);
        chk("mrst_err", 32'(sync_err), 32'd0);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("fresh_out", 32'(out_bus), 32'b1111);
        chk("fresh_fv", 32'(frame_valid), 32'd1);

        // Repeated early syncs: 300 errors
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("sat_err", 32'(sync_err), 32'd1);
        chk("sat_locked", 32'(locked), 32'd1);
`ifdef TDM_DEMUX_ERR_CNT_EN
        chk("sat_count", 32'(err_count), 32'd255);
        idle(2);
        chk("sat_hold", 32'(err_count), 32'd255);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("cnt_rst", 32'(err_count), 32'd0);
`endif
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1_4.md
Name: tdm_demux_1_4

Overview:
Time-division 1-to-4 demultiplexer. It is the receive end of a 4:1 mux link whose select rotates 0,1,2,3 every sample.
- Tracks the slot position of an incoming sample stream, using a frame-sync marker on slot 0.
- Routes each sample to its channel and presents all four channels as one registered parallel word per frame.
- Flags sync loss and re-acquires automatically.

Parameters:
W, 1, width in bits of one channel sample (slot).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  W  sample from the muxed link
din_valid  input  1  din carries a valid sample this cycle
frame_sync  input  1  qualified by din_valid; marks din as slot 0 of a frame
out_bus  output  4*W  last complete frame; bits [W-1:0]=ch0 ... [4W-1:3W]=ch3
frame_valid  output  1  one-cycle pulse: out_bus updated this cycle
sel  output  2  slot index expected for the next valid sample (mirrors transmitter select)
locked  output  1  high while in LOCKED state
sync_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (rst=1 at a clock edge) forces all of the following, taking priority over every other event, including a frame in progress (the partial frame is discarded):
  - out_bus=0, frame_valid=0, sel=0, locked=0, sync_err=0
  - shadow registers cleared
  - state=HUNT
- Only din_valid=1 cycles advance anything. When din_valid=0, all state holds and frame_valid/sync_err are 0. Gaps of any length are legal between samples.
- State machine:
  - HUNT:
    - din_valid & frame_sync: store din in shadow[0], set sel<=1, go to LOCKED.
    - din_valid & !frame_sync: sample dropped, no error, stay in HUNT.
  - LOCKED, for each din_valid:
    - sel==0 & frame_sync: store in shadow[0], sel<=1.
    - sel==0 & !frame_sync: sync_err pulse, sample dropped, sel<=0, go to HUNT.
    - sel!=0 & frame_sync (early sync): sync_err pulse, partial frame discarded, sample taken as the new slot 0, sel<=1, stay LOCKED.
    - sel==1 or 2 & !frame_sync: store in shadow[sel], sel<=sel+1.
    - sel==3 & !frame_sync: out_bus<={din,shadow[2],shadow[1],shadow[0]}, frame_valid=1, sel wraps to 0.
- Latency: out_bus and frame_valid are registered and become valid on the edge after the slot-3 sample is presented, i.e. 1 cycle.
- out_bus changes only with frame_valid. It holds its last value through errors and HUNT.
- sync_err and frame_valid are never asserted in the same cycle.
- locked is registered and follows the state.
- sel wraps 3->0 modulo 4. No other arithmetic is involved.

Optional Feature:
- Macro: TDM_DEMUX_ERR_CNT_EN.
- Defined:
  - Adds output port err_count, 8 bits: a saturating count of sync_err pulses.
  - Reset value 0. Increments in the same cycle sync_err asserts.
  - Sticks at 255, with no wrap.
  - Cleared only by rst.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset then frame (W=1): din 0,1,0,1 on slots 0..3, frame_sync with the first sample -> one cycle after slot 3: out_bus=4'b1010, frame_valid pulses once, locked=1, sel=0.
- Gapped frame: same samples with din_valid low for 3 cycles between each -> identical out_bus=4'b1010. frame_valid only after the 4th valid sample. sel steps 1,2,3,0 and holds during the gaps.
- Early sync: frame_sync on slot 2 with din=1 -> sync_err pulse, sel=1, locked stays 1. The next 3 samples 1,1,0 -> out_bus=4'b0111. The previous out_bus is unchanged until then.
- Missing sync at slot 0 while LOCKED -> sync_err pulse, locked=0, sel=0. Samples without frame_sync are dropped silently until the next sync.
- Mid-frame reset after slots 0..1 -> all outputs 0 on the next cycle. A fresh full frame 1,1,1,1 then yields out_bus=4'b1111.
- TDM_DEMUX_ERR_CNT_EN defined: 300 forced early syncs -> err_count reaches 255 and holds. rst returns it to 0.
